tdc_echo_packer: RTL and testbench

Downstream consumer of the TDC output stream. It collects each per-shot burst of 0–3 echo beats (10-bit ToF plus 4-bit intensity) into one 48-bit shot record and buffers records in a small show-ahead FIFO. It then presents them to core logic over a valid/ready stream. It also tags each shot with a sequence number, detects burst-framing errors and counts shots dropped on overflow.

---
 rtl/tdc_echo_packer.sv | 211 +++++++++++++++++++++
 tb/tb_tdc_echo_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_echo_packer.sv
// tdc_echo_packer: packs per-shot TDC echo bursts into 48-bit shot records and
// buffers them in a show-ahead FIFO behind a valid/ready stream.
module tdc_echo_packer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  TDC_Odata,
    input  logic [3:0]  TDC_Oint,
    input  logic [1:0]  TDC_Onum,
    input  logic        TDC_Olast,
    input  logic        TDC_Ovalid,
    output logic        TDC_Oready,
    input  logic        clr,
    output logic [47:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        err,
    output logic [7:0]  drop_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    num_q, num_d;
    logic [1:0]    beat_q, beat_d;
    logic [3:0]    seq_q, seq_d;
    logic [3:0]    shot_seq_q, shot_seq_d;
    logic          drop_q, drop_d;
    logic [13:0]   echo_q [3];
    logic [13:0]   echo_d [3];
    logic [47:0]   fifo_q [DEPTH];
    logic [47:0]   fifo_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          pop_s;
    logic          push_s;
    logic          accept_s;
    logic          final_s;
    logic          req_last_s;
    logic [47:0]   rec_s;
    logic [CW-1:0] wr_idx_s;

    assign pop_s = valid_q && m_ready;

    // Burst framing FSM: tracks beats, builds the record, flags errors and drops.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        beat_d     = beat_q;
        seq_d      = seq_q;
        shot_seq_d = shot_seq_q;
        drop_d     = drop_q;
        echo_d     = echo_q;
        err_d      = err_q;
        drop_cnt_d = drop_cnt_q;
        accept_s   = !drop_q;
        final_s    = 1'b0;
        req_last_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (TDC_Ovalid) begin
                    num_d      = TDC_Onum;
                    shot_seq_d = seq_q;
                    seq_d      = seq_q + 4'd1;
                    // A same-cycle pop frees a slot for this shot.
                    accept_s   = (count_q < CW'(DEPTH)) || pop_s;
                    drop_d     = !accept_s;
                    if (!accept_s && (drop_cnt_q != 8'hFF)) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end else begin
                        drop_cnt_d = drop_cnt_q;
                    end
                    echo_d[0]  = (TDC_Onum != 2'd0) ? {TDC_Oint, TDC_Odata} : 14'd0;
                    echo_d[1]  = 14'd0;
                    echo_d[2]  = 14'd0;
                    final_s    = (TDC_Onum <= 2'd1);
                    req_last_s = (TDC_Onum == 2'd1);
                    if (final_s) begin
                        state_d = IDLE;
                        beat_d  = 2'd0;
                    end else begin
                        state_d = COLLECT;
                        beat_d  = 2'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (TDC_Ovalid) begin
                    for (int i = 1; i < 3; i++) begin
                        if (beat_q == 2'(i)) begin
                            echo_d[i] = {TDC_Oint, TDC_Odata};
                        end else begin
                            echo_d[i] = echo_q[i];
                        end
                    end
                    final_s    = (beat_q == (num_q - 2'd1));
                    req_last_s = final_s;
                    if (final_s) begin
                        state_d = IDLE;
                        beat_d  = 2'd0;
                    end else begin
                        state_d = COLLECT;
                        beat_d  = beat_q + 2'd1;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
        endcase
        push_s = TDC_Ovalid && final_s && accept_s;
        rec_s  = {shot_seq_d, num_d, echo_d[2], echo_d[1], echo_d[0]};
        if (TDC_Ovalid && (TDC_Olast != req_last_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (clr) begin
            err_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end else begin
            drop_cnt_d = drop_cnt_d;
        end
    end

    // Shifting record FIFO: entry 0 is the head, so m_data comes straight from a flop.
    always_comb begin
        fifo_d   = fifo_q;
        wr_idx_s = pop_s ? (count_q - CW'(1)) : count_q;
        if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i + 1];
            end
        end else begin
            fifo_d[0] = fifo_q[0];
        end
        if (push_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx_s == CW'(i)) begin
                    fifo_d[i] = rec_s;
                end else begin
                    fifo_d[i] = fifo_d[i];
                end
            end
        end else begin
            fifo_d[0] = fifo_d[0];
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CW'(0));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= 2'd0;
            beat_q     <= 2'd0;
            seq_q      <= 4'd0;
            shot_seq_q <= 4'd0;
            drop_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                echo_q[i] <= 14'd0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 48'd0;
            end
            count_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            beat_q     <= beat_d;
            seq_q      <= seq_d;
            shot_seq_q <= shot_seq_d;
            drop_q     <= drop_d;
            echo_q     <= echo_d;
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign TDC_Oready = (state_q == IDLE) && (count_q < CW'(DEPTH));
    assign m_data     = fifo_q[0];
    assign m_valid    = valid_q;
    assign err        = err_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_tdc_echo_packer.sv
// Directed bench for tdc_echo_packer: a per-cycle vector table plus hand-written
// sequences for overflow, full-with-pop, sequence wrap and mid-burst reset.
module tb_tdc_echo_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  TDC_Odata;
    logic [3:0]  TDC_Oint;
    logic [1:0]  TDC_Onum;
    logic        TDC_Olast;
    logic        TDC_Ovalid;
    logic        TDC_Oready;
    logic        clr;
    logic [47:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        err;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    tdc_echo_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .TDC_Odata  (TDC_Odata),
        .TDC_Oint   (TDC_Oint),
        .TDC_Onum   (TDC_Onum),
        .TDC_Olast  (TDC_Olast),
        .TDC_Ovalid (TDC_Ovalid),
        .TDC_Oready (TDC_Oready),
        .clr        (clr),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .err        (err),
        .drop_cnt   (drop_cnt)
    );

    always #2 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  n;
        logic [3:0]  it;
        logic [9:0]  d;
        logic        l;
        logic        c;
        logic        mr;
        logic        ev;
        logic [47:0] ed;
        logic        ee;
        logic        eo;
    } vec_t;

    vec_t        tbl [12];
    logic [47:0] expq [$];

    function automatic logic [47:0] rec(input logic [3:0] s, input logic [1:0] n,
                                        input logic [3:0] i2, input logic [9:0] d2,
                                        input logic [3:0] i1, input logic [9:0] d1,
                                        input logic [3:0] i0, input logic [9:0] d0);
        return {s, n, i2, d2, i1, d1, i0, d0};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] n, input logic [3:0] it, input logic [9:0] d,
                        input logic l);
        TDC_Ovalid = 1'b1;
        TDC_Onum   = n;
        TDC_Oint   = it;
        TDC_Odata  = d;
        TDC_Olast  = l;
        tick();
        TDC_Ovalid = 1'b0;
        TDC_Olast  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; TDC_Odata = 10'd0; TDC_Oint = 4'd0; TDC_Onum = 2'd0;
        TDC_Olast = 1'b0; TDC_Ovalid = 1'b0; clr = 1'b0; m_ready = 1'b1;
        do_reset();

        chk("rst_oready", {47'd0, TDC_Oready}, 48'd1);
        chk("rst_mvalid", {47'd0, m_valid}, 48'd0);
        chk("rst_mdata", m_data, 48'd0);
        chk("rst_err", {47'd0, err}, 48'd0);
        chk("rst_drop", {40'd0, drop_cnt}, 48'd0);

        //         v     n     it     d        l     c     mr    ev    ed                                                          ee    eo
        tbl[0]  = '{1'b1, 2'd2, 4'd3, 10'h012, 1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 4'd7, 10'h045, 1'b1, 1'b0, 1'b1, 1'b1,
                    rec(4'd0, 2'd2, 4'd0, 10'd0, 4'd7, 10'h045, 4'd3, 10'h012), 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 2'd0, 4'd0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 4'd0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1,
                    48'h1000_0000_0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'd3, 4'd1, 10'h100, 1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 4'd2, 10'h200, 1'b1, 1'b0, 1'b1, 1'b0, 48'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 4'd0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 4'hF, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b1,
                    rec(4'd2, 2'd3, 4'hF, 10'h3FF, 4'd2, 10'h200, 4'd1, 10'h100), 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 4'd0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 48'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'd1, 4'd5, 10'h0AA, 1'b0, 1'b0, 1'b1, 1'b1,
                    rec(4'd3, 2'd1, 4'd0, 10'd0, 4'd0, 10'd0, 4'd5, 10'h0AA), 1'b1, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 4'd9, 10'h155, 1'b1, 1'b1, 1'b1, 1'b1,
                    48'h4000_0000_0000, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 4'd0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 1'b0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            TDC_Ovalid = tbl[i].v;  TDC_Onum = tbl[i].n;  TDC_Oint = tbl[i].it;
            TDC_Odata  = tbl[i].d;  TDC_Olast = tbl[i].l; clr = tbl[i].c;
            m_ready    = tbl[i].mr;
            tick();
            chk($sformatf("vec%0d_mvalid", i), {47'd0, m_valid}, {47'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_mdata", i), m_data, tbl[i].ed);
            end
            chk($sformatf("vec%0d_err", i), {47'd0, err}, {47'd0, tbl[i].ee});
            chk($sformatf("vec%0d_oready", i), {47'd0, TDC_Oready}, {47'd0, tbl[i].eo});
        end
        TDC_Ovalid = 1'b0; clr = 1'b0;

        // Overflow: DEPTH+1 single-echo shots with the consumer stalled.
        do_reset();
        m_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            beat(2'd1, 4'(k), 10'(k * 3 + 1), 1'b1);
            chk($sformatf("ovf_oready%0d", k), {47'd0, TDC_Oready},
                {47'd0, (k + 1 < DEPTH)});
        end
        chk("ovf_drop", {40'd0, drop_cnt}, 48'd1);
        chk("ovf_err", {47'd0, err}, 48'd0);
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("ovf_valid%0d", k), {47'd0, m_valid}, 48'd1);
            chk($sformatf("ovf_rec%0d", k), m_data,
                rec(4'(k), 2'd1, 4'd0, 10'd0, 4'd0, 10'd0, 4'(k), 10'(k * 3 + 1)));
            m_ready = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        chk("ovf_empty", {47'd0, m_valid}, 48'd0);
        beat(2'd1, 4'hA, 10'h155, 1'b1);
        chk("ovf_gap", m_data, rec(4'(DEPTH + 1), 2'd1, 4'd0, 10'd0, 4'd0, 10'd0, 4'hA, 10'h155));

        // Full FIFO with a pop in the same cycle as a new first beat.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_drop", {40'd0, drop_cnt}, 48'd0);
        for (int k = 0; k < DEPTH - 1; k++) begin
            beat(2'd1, 4'(k + 1), 10'(k + 32), 1'b1);
            expq.push_back(rec(4'(DEPTH + 2 + k), 2'd1, 4'd0, 10'd0, 4'd0, 10'd0,
                               4'(k + 1), 10'(k + 32)));
        end
        chk("full_oready", {47'd0, TDC_Oready}, 48'd0);
        m_ready = 1'b1;
        beat(2'd2, 4'd9, 10'h091, 1'b0);
        m_ready = 1'b0;
        beat(2'd2, 4'd6, 10'h066, 1'b1);
        expq.push_back(rec(4'(2 * DEPTH + 1), 2'd2, 4'd0, 10'd0, 4'd6, 10'h066, 4'd9, 10'h091));
        chk("fullpop_drop", {40'd0, drop_cnt}, 48'd0);
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("fullpop_rec%0d", k), m_data, expq[k]);
            m_ready = 1'b1;
            tick();
        end
        chk("fullpop_empty", {47'd0, m_valid}, 48'd0);

        // Back-to-back shots at full rate; sequence number wraps after 15.
        do_reset();
        m_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            beat(2'd1, 4'(j), 10'(j + 100), 1'b1);
            chk($sformatf("wrap_valid%0d", j), {47'd0, m_valid}, 48'd1);
            chk($sformatf("wrap_rec%0d", j), m_data,
                rec(4'(j % 16), 2'd1, 4'd0, 10'd0, 4'd0, 10'd0, 4'(j), 10'(j + 100)));
        end

        // Reset in the middle of a burst with a record pending.
        m_ready = 1'b0;
        tick();
        beat(2'd1, 4'd1, 10'h001, 1'b1);
        beat(2'd3, 4'd2, 10'h002, 1'b0);
        beat(2'd3, 4'd3, 10'h003, 1'b0);
        chk("pre_rst_oready", {47'd0, TDC_Oready}, 48'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_mvalid", {47'd0, m_valid}, 48'd0);
        chk("midrst_oready", {47'd0, TDC_Oready}, 48'd1);
        tick();
        rst_n = 1'b1;
        tick();
        beat(2'd1, 4'd4, 10'h004, 1'b1);
        chk("post_rst_rec", m_data, rec(4'd0, 2'd1, 4'd0, 10'd0, 4'd0, 10'd0, 4'd4, 10'h004));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
